// File: rtl/hazard_stall_ctrl_if.sv
// D/E/M hazard inputs and stall/mult-div status outputs of the stall controller.
// The DUT takes the slave modport.
interface hazard_stall_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic       d_is_md;
  logic       e_we;
  logic [4:0] e_dst;
  logic [1:0] e_tnew;
  logic       m_we;
  logic [4:0] m_dst;
  logic [1:0] m_tnew;
  logic       e_md_start;
  logic       e_md_is_div;
  logic       pc_en;
  logic       d_en;
  logic       e_flush;
  logic       md_busy;
  logic       md_done;
  logic       md_overlap_err;

  // There is no valid/ready pair on this interface.
  // The stall outputs answer the inputs of the same cycle: when d_en is low,
  // the pipeline holds F/D and the PC and puts a bubble into E. Stall is
  // never a request that waits for an acknowledge.
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    output e_we, e_dst, e_tnew, m_we, m_dst, m_tnew,
    output e_md_start, e_md_is_div,
    input  pc_en, d_en, e_flush, md_busy, md_done, md_overlap_err
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    input  e_we, e_dst, e_tnew, m_we, m_dst, m_tnew,
    input  e_md_start, e_md_is_div,
    output pc_en, d_en, e_flush, md_busy, md_done, md_overlap_err
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew RAW detection and mult/div busy sequencing.
// Optional stall performance counters are built when STALL_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_ctrl_if.slave   bus,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          md_stall_cycles,
`endif
  output logic                 dbg_state_o,
  output logic [CNT_W-1:0]     dbg_count_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic stall_rs, stall_rt, md_stall, stall;
  logic md_busy, md_done;

  // A source register stalls only when its producer's result arrives after D consumes it.
  // Register 0 never stalls.
  always_comb begin
    stall_rs = (bus.d_rs != 5'd0) &&
               ((bus.e_we && (bus.e_dst == bus.d_rs) && (bus.e_tnew > bus.d_tuse_rs)) ||
                (bus.m_we && (bus.m_dst == bus.d_rs) && (bus.m_tnew > bus.d_tuse_rs)));
    stall_rt = (bus.d_rt != 5'd0) &&
               ((bus.e_we && (bus.e_dst == bus.d_rt) && (bus.e_tnew > bus.d_tuse_rt)) ||
                (bus.m_we && (bus.m_dst == bus.d_rt) && (bus.m_tnew > bus.d_tuse_rt)));
  end

  assign md_busy  = (state_q == BUSY);
  assign md_done  = md_busy && (count_q == CNT_ONE);
  assign md_stall = bus.d_is_md && (bus.e_md_start || md_busy);
  assign stall    = stall_rs | stall_rt | md_stall;

  assign bus.pc_en          = ~stall;
  assign bus.d_en           = ~stall;
  assign bus.e_flush        = stall;
  assign bus.md_busy        = md_busy;
  assign bus.md_done        = md_done;
  assign bus.md_overlap_err = err_q;
  assign dbg_state_o        = state_q;
  assign dbg_count_o        = count_q;

  // A start seen while BUSY is an upstream bug.
  // It is flagged and dropped; this includes the final busy cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.e_md_start) begin
          state_d = BUSY;
          count_d = bus.e_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (bus.e_md_start) err_d = 1'b1;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_cnt_q, md_cnt_d;

  always_comb begin
    stall_cnt_d = stall    ? stall_cnt_q + 32'd1 : stall_cnt_q;
    md_cnt_d    = md_stall ? md_cnt_q + 32'd1    : md_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign md_stall_cycles = md_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a random and directed driver, a "busy cycles remaining" reference model,
// and a monitor that pops the expected queue.
module tb_hazard_stall_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus ();
  logic       dbg_state;
  logic [3:0] dbg_count;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
`ifdef STALL_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles),
`endif
    .dbg_state_o     (dbg_state),
    .dbg_count_o     (dbg_count)
  );

  typedef struct {
    logic [4:0] d_rs, d_rt;
    logic [1:0] d_tuse_rs, d_tuse_rt;
    logic       d_is_md;
    logic       e_we;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic       m_we;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic       e_md_start, e_md_is_div;
  } stim_t;

  // ---------------- reference model state ----------------
  int rem_m;          // busy cycles still to run after this one
  bit err_m;
  int stall_cnt_m, md_cnt_m;

  logic [9:0]  exp_q[$];   // {count, pc_en, d_en, e_flush, md_busy, md_done, err}
  logic [63:0] exp_perf_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  function automatic bit raw_hz(input logic [4:0] src, input logic [1:0] tuse, input stim_t s);
    bit hit_e, hit_m;
    hit_e = s.e_we && (s.e_dst == src) && (int'(s.e_tnew) > int'(tuse));
    hit_m = s.m_we && (s.m_dst == src) && (int'(s.m_tnew) > int'(tuse));
    return (src != 5'd0) && (hit_e || hit_m);
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.d_rs = '0; s.d_rt = '0; s.d_tuse_rs = 2'd3; s.d_tuse_rt = 2'd3; s.d_is_md = 1'b0;
    s.e_we = 1'b0; s.e_dst = '0; s.e_tnew = '0;
    s.m_we = 1'b0; s.m_dst = '0; s.m_tnew = '0;
    s.e_md_start = 1'b0; s.e_md_is_div = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim(input bit allow_overlap);
    stim_t s;
    s.d_rs = 5'($urandom_range(0, 3)); s.d_rt = 5'($urandom_range(0, 3));
    s.d_tuse_rs = 2'($urandom_range(0, 3)); s.d_tuse_rt = 2'($urandom_range(0, 3));
    s.d_is_md = ($urandom_range(0, 2) == 0);
    s.e_we = 1'($urandom_range(0, 1)); s.e_dst = 5'($urandom_range(0, 3)); s.e_tnew = 2'($urandom_range(0, 2));
    s.m_we = 1'($urandom_range(0, 1)); s.m_dst = 5'($urandom_range(0, 3)); s.m_tnew = 2'($urandom_range(0, 1));
    s.e_md_start = (allow_overlap || rem_m == 0) && ($urandom_range(0, 5) == 0);
    s.e_md_is_div = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.d_rs = s.d_rs; bus.d_rt = s.d_rt; bus.d_tuse_rs = s.d_tuse_rs; bus.d_tuse_rt = s.d_tuse_rt;
    bus.d_is_md = s.d_is_md; bus.e_we = s.e_we; bus.e_dst = s.e_dst; bus.e_tnew = s.e_tnew;
    bus.m_we = s.m_we; bus.m_dst = s.m_dst; bus.m_tnew = s.m_tnew;
    bus.e_md_start = s.e_md_start; bus.e_md_is_div = s.e_md_is_div;
  endtask

  task automatic model_reset();
    rem_m = 0; err_m = 1'b0; stall_cnt_m = 0; md_cnt_m = 0;
  endtask

  // ---------------- driver: one cycle of stimulus plus expectation ----------------
  task automatic drive_cycle(input stim_t s);
    bit st, mds;
    @(negedge clk);
    apply(s);
    cyc++;
    mds = s.d_is_md && (s.e_md_start || rem_m > 0);
    st  = raw_hz(s.d_rs, s.d_tuse_rs, s) || raw_hz(s.d_rt, s.d_tuse_rt, s) || mds;
    exp_q.push_back({4'(rem_m), !st, !st, st, (rem_m > 0), (rem_m == 1), err_m});
    exp_perf_q.push_back({32'(stall_cnt_m), 32'(md_cnt_m)});
    if (st)  stall_cnt_m++;
    if (mds) md_cnt_m++;
    if (rem_m > 0) begin
      if (s.e_md_start) err_m = 1'b1;
      rem_m--;
    end else if (s.e_md_start) begin
      rem_m = s.e_md_is_div ? 10 : 5;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [9:0]  got, want;
    logic [63:0] pwant;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want  = exp_q.pop_front();
        pwant = exp_perf_q.pop_front();
        got = {dbg_count, bus.pc_en, bus.d_en, bus.e_flush, bus.md_busy, bus.md_done, bus.md_overlap_err};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs cycle=%0d got=%b exp=%b (count,pc_en,d_en,e_flush,busy,done,err)",
                   cyc, got, want);
        end
`ifdef STALL_PERF_CNT_EN
        checks++;
        if ({stall_cycles, md_stall_cycles} !== pwant) begin
          errors++;
          $display("FAIL perf_counters cycle=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                   stall_cycles, md_stall_cycles, pwant[63:32], pwant[31:0]);
        end
`else
        pwant = '0;
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    stim_t s;
    reset = 1'b0;
    apply(idle_stim());
    model_reset();
    #12;
    check("reset_pc_en", 32'(bus.pc_en), 32'd1);
    check("reset_e_flush", 32'(bus.e_flush), 32'd0);
    check("reset_busy_done_err", {29'd0, bus.md_busy, bus.md_done, bus.md_overlap_err}, 32'd0);
    check("reset_count", 32'(dbg_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // load-use, then the load sits in M for one more cycle
    s = idle_stim(); s.e_we = 1; s.e_dst = 8; s.e_tnew = 2; s.d_rs = 8; s.d_tuse_rs = 1; drive_cycle(s);
    s = idle_stim(); s.m_we = 1; s.m_dst = 8; s.m_tnew = 1; s.d_rs = 8; s.d_tuse_rs = 0; drive_cycle(s);
    s = idle_stim(); s.d_rs = 8; s.d_tuse_rs = 0; drive_cycle(s);
    // $0 immunity on rs and rt
    s = idle_stim(); s.e_we = 1; s.e_dst = 0; s.e_tnew = 2; s.d_rs = 0; s.d_tuse_rs = 0;
    s.d_rt = 0; s.d_tuse_rt = 0; drive_cycle(s);
    // rt hazard from M
    s = idle_stim(); s.m_we = 1; s.m_dst = 5; s.m_tnew = 1; s.d_rt = 5; s.d_tuse_rt = 0; drive_cycle(s);

    // mult with a md instruction waiting in D
    s = idle_stim(); s.e_md_start = 1; s.d_is_md = 1; drive_cycle(s);
    for (int i = 0; i < 7; i++) begin s = idle_stim(); s.d_is_md = 1; drive_cycle(s); end
    // div with non-md instructions in D
    s = idle_stim(); s.e_md_start = 1; s.e_md_is_div = 1; drive_cycle(s);
    for (int i = 0; i < 12; i++) drive_cycle(idle_stim());

    for (int i = 0; i < 300; i++) drive_cycle(rand_stim(1'b0));
    for (int i = 0; i < 12 && rem_m != 0; i++) drive_cycle(idle_stim());

    // overlap: a start while count is 7 must not reload the count
    s = idle_stim(); s.e_md_start = 1; s.e_md_is_div = 1; drive_cycle(s);
    for (int i = 0; i < 12 && rem_m != 7; i++) drive_cycle(idle_stim());
    s = idle_stim(); s.e_md_start = 1; drive_cycle(s);
    for (int i = 0; i < 12 && rem_m != 0; i++) drive_cycle(idle_stim());
    for (int i = 0; i < 4; i++) drive_cycle(idle_stim());

    for (int i = 0; i < 200; i++) drive_cycle(rand_stim(1'b1));
    for (int i = 0; i < 12 && rem_m != 0; i++) drive_cycle(idle_stim());

    // asynchronous reset in the middle of a div
    s = idle_stim(); s.e_md_start = 1; s.e_md_is_div = 1; drive_cycle(s);
    for (int i = 0; i < 12 && rem_m != 4; i++) drive_cycle(idle_stim());
    #3;
    reset = 1'b0;
    apply(idle_stim());
    #1;
    check("async_reset_busy", 32'(bus.md_busy), 32'd0);
    check("async_reset_done", 32'(bus.md_done), 32'd0);
    check("async_reset_count", 32'(dbg_count), 32'd0);
    check("async_reset_err_cleared", 32'(bus.md_overlap_err), 32'd0);
`ifdef STALL_PERF_CNT_EN
    check("async_reset_stall_cycles", stall_cycles, 32'd0);
    check("async_reset_md_stall_cycles", md_stall_cycles, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 100; i++) drive_cycle(rand_stim(1'b0));
    drive_cycle(idle_stim());
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
